// File: rtl/p4_adder_pkg.sv
// p4_adder_pkg: shared width constants, LFSR polynomial, checker FSM states and corner vectors.
package p4_adder_pkg;

    localparam int nbit           = 32;
    localparam int nbit_per_block = 4;

    // Galois right-shift taps for x^32+x^22+x^2+x+1
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, CHECK, FINISH} state_t;

    // Index 0 is the first vector of a run; narrower adders use the low NBIT bits
    localparam logic [3:0][31:0] CORNER_A   = {32'h5555_5555, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    localparam logic [3:0][31:0] CORNER_B   = {32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    localparam logic [3:0]       CORNER_CIN = 4'b1110;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/p4_lfsr32.sv
// p4_lfsr32: 32-bit Galois LFSR; each enabled cycle advances two steps (one A/B operand pair).
module p4_lfsr32
    import p4_adder_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [31:0] state
);

    logic [31:0] r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= SEED;
        else if (step)
            r_state <= lfsr_next(lfsr_next(r_state));
    end

    assign state = r_state;

endmodule

// File: rtl/p4_adder_stim_checker.sv
// p4_adder_stim_checker: LFSR-driven operand source and sum checker for the P4 adder.
// Define P4_CORNER_VEC_EN to start every run with four fixed corner vectors.
module p4_adder_stim_checker
    import p4_adder_pkg::*;
#(
    parameter int          NBIT    = nbit,
    parameter int          LATENCY = 0,
    parameter int          NUM_VEC = 256,
    parameter logic [31:0] SEED    = 32'hACE1_2468
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic [NBIT-1:0] a,
    output logic [NBIT-1:0] b,
    output logic            cin,
    input  logic [NBIT-1:0] s,
    input  logic            cout,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [15:0]     err_count,
    output logic [15:0]     vec_count,
    output logic [2*NBIT:0] first_err
);

    state_t          r_state, w_next;
    logic [3:0]      r_wait;
    logic [NBIT:0]   r_golden;
    logic [31:0]     w_lfsr, w_lfsr_b;
    logic [NBIT-1:0] w_a, w_b;
    logic [NBIT:0]   w_golden;
    logic            w_cin, w_corner, w_step, w_mismatch;

`ifdef P4_CORNER_VEC_EN
    assign w_corner = vec_count < 16'd4;
`else
    assign w_corner = 1'b0;
`endif

    // Corner vectors leave the LFSR untouched so the random sequence resumes where it left off
    assign w_step = (r_state == LOAD) && !abort && !w_corner;

    p4_lfsr32 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (w_step),
        .state (w_lfsr)
    );

    assign w_lfsr_b   = lfsr_next(w_lfsr);
    assign w_a        = w_corner ? CORNER_A[vec_count[1:0]][NBIT-1:0] : w_lfsr[NBIT-1:0];
    assign w_b        = w_corner ? CORNER_B[vec_count[1:0]][NBIT-1:0] : w_lfsr_b[NBIT-1:0];
    assign w_cin      = w_corner ? CORNER_CIN[vec_count[1:0]] : w_a[0] ^ w_b[NBIT-1];
    assign w_golden   = {1'b0, w_a} + {1'b0, w_b} + {{NBIT{1'b0}}, w_cin};
    assign w_mismatch = {cout, s} != r_golden;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (abort)
            w_next = IDLE;
        else
            case (r_state)
                IDLE:    w_next = start ? LOAD : IDLE;
                LOAD:    w_next = (LATENCY > 0) ? WAIT : CHECK;
                WAIT:    w_next = (r_wait == 4'd0) ? CHECK : WAIT;
                CHECK:   w_next = (vec_count + 16'd1 == 16'(NUM_VEC)) ? FINISH : LOAD;
                default: w_next = IDLE;
            endcase
    end

    // Everything freezes while abort is high, so an aborted run keeps its counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a         <= '0;
            b         <= '0;
            cin       <= 1'b0;
            r_golden  <= '0;
            r_wait    <= '0;
            err_count <= '0;
            vec_count <= '0;
            first_err <= '0;
        end else if (!abort) begin
            if (r_state == IDLE && start) begin
                err_count <= '0;
                vec_count <= '0;
                first_err <= '0;
            end
            if (r_state == LOAD) begin
                a        <= w_a;
                b        <= w_b;
                cin      <= w_cin;
                r_golden <= w_golden;
                r_wait   <= 4'(LATENCY - 1);
            end
            if (r_state == WAIT)
                r_wait <= r_wait - 4'd1;
            if (r_state == CHECK) begin
                vec_count <= vec_count + 16'd1;
                if (w_mismatch && err_count != 16'hFFFF)
                    err_count <= err_count + 16'd1;
                if (w_mismatch && err_count == 16'd0)
                    first_err <= {a, b, cin};
            end
        end
    end

    assign busy = r_state != IDLE;
    assign done = r_state == FINISH;
    assign pass = done && err_count == 16'd0;

endmodule

// File: tb/tb_p4_adder_stim_checker.sv
// tb_p4_adder_stim_checker: directed checks of the stimulus checker against good, faulty and pipelined adder models.
module tb_p4_adder_stim_checker;

    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fault = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // dut0: combinational adder, LATENCY 0, 16 vectors, optional s[5] stuck-at-0
    logic        start0 = 1'b0, abort0 = 1'b0;
    logic [31:0] a0, b0, s0;
    logic        cin0, cout0, busy0, done0, pass0;
    logic [15:0] err0, vec0;
    logic [64:0] fe0;
    logic [32:0] sum0;

    assign sum0  = {1'b0, a0} + {1'b0, b0} + {32'b0, cin0};
    assign s0    = sum0[31:0] & ~(fault ? 32'h20 : 32'h0);
    assign cout0 = sum0[32];

    p4_adder_stim_checker #(.LATENCY(0), .NUM_VEC(16), .SEED(SEED)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .a(a0), .b(b0), .cin(cin0), .s(s0), .cout(cout0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .vec_count(vec0), .first_err(fe0)
    );

    // dut3 and dut2: both face a 3-stage pipelined adder; only dut3 is configured to match it
    logic        start3 = 1'b0, abort3 = 1'b0, start2 = 1'b0, abort2 = 1'b0;
    logic [31:0] a3, b3, a2, b2;
    logic        cin3, busy3, done3, pass3, cin2, busy2, done2, pass2;
    logic [15:0] err3, vec3, err2, vec2;
    logic [64:0] fe3, fe2;
    logic [32:0] p3 [3];
    logic [32:0] p2 [3];

    always_ff @(posedge clk) begin
        p3[0] <= {1'b0, a3} + {1'b0, b3} + {32'b0, cin3};
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        p2[0] <= {1'b0, a2} + {1'b0, b2} + {32'b0, cin2};
        p2[1] <= p2[0];
        p2[2] <= p2[1];
    end

    p4_adder_stim_checker #(.LATENCY(3), .NUM_VEC(8), .SEED(SEED)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3),
        .a(a3), .b(b3), .cin(cin3), .s(p3[2][31:0]), .cout(p3[2][32]),
        .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .vec_count(vec3), .first_err(fe3)
    );

    p4_adder_stim_checker #(.LATENCY(2), .NUM_VEC(8), .SEED(SEED)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .a(a2), .b(b2), .cin(cin2), .s(p2[2][31:0]), .cout(p2[2][32]),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .vec_count(vec2), .first_err(fe2)
    );

    logic [31:0] m0;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        logic [31:0] y;
        y = x >> 1;
        if (x[0]) begin
            y[31] = ~y[31];
            y[21] = ~y[21];
            y[1]  = ~y[1];
            y[0]  = ~y[0];
        end
        return y;
    endfunction

    function automatic void gen_vec(inout logic [31:0] st, input int idx,
                                    output logic [31:0] ea, output logic [31:0] eb, output logic ec);
`ifdef P4_CORNER_VEC_EN
        if (idx < 4) begin
            ea = (idx == 0) ? 32'h0 : (idx == 3) ? 32'h5555_5555 : 32'hFFFF_FFFF;
            eb = (idx == 2) ? 32'hFFFF_FFFF : (idx == 3) ? 32'hAAAA_AAAA : 32'h0;
            ec = idx != 0;
            return;
        end
`endif
        ea = st;
        eb = lfsr_step(st);
        ec = ea[0] ^ eb[31];
        st = lfsr_step(eb);
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if ({a0, b0, cin0} !== 65'd0) begin
            errors++;
            $display("FAIL reset_operands: got %h expected 0", {a0, b0, cin0});
        end
        checks++;
        if ({busy0, done0, pass0} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {busy0, done0, pass0});
        end
        checks++;
        if ({err0, vec0, fe0} !== 97'd0) begin
            errors++;
            $display("FAIL reset_counters: got %h/%h/%h expected 0", err0, vec0, fe0);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] ea, eb;
        logic        ec;
        int          cyc;
        m0 = SEED;
        fault = 1'b0;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        checks++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b expected 1", busy0);
        end
        cyc = 1;
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            cyc++;
            gen_vec(m0, v, ea, eb, ec);
            checks++;
            if ({a0, b0, cin0} !== {ea, eb, ec}) begin
                errors++;
                $display("FAIL basic_vec%0d: got %h/%h/%b expected %h/%h/%b", v, a0, b0, cin0, ea, eb, ec);
            end
`ifdef P4_CORNER_VEC_EN
            if (v == 2) begin
                checks++;
                if ({a0, b0, cin0, cout0, s0} !== {32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFF}) begin
                    errors++;
                    $display("FAIL corner_vec2: got %h/%h/%b -> %b/%h", a0, b0, cin0, cout0, s0);
                end
            end
`endif
            if (v < 15) begin
                @(negedge clk);
                cyc++;
            end
        end
        while (done0 !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== 33) begin
            errors++;
            $display("FAIL basic_done_cycle: got %0d expected 33", cyc);
        end
        checks++;
        if ({done0, pass0, err0, vec0} !== {1'b1, 1'b1, 16'd0, 16'd16}) begin
            errors++;
            $display("FAIL basic_result: got done=%b pass=%b err=%0d vec=%0d expected 1 1 0 16", done0, pass0, err0, vec0);
        end
        @(negedge clk);
        checks++;
        if ({busy0, done0, pass0} !== 3'b000) begin
            errors++;
            $display("FAIL basic_idle: got %b expected 000", {busy0, done0, pass0});
        end
    endtask

    task automatic test_stuck_bit();
        logic [31:0] ea, eb;
        logic        ec;
        logic [32:0] g;
        logic [64:0] exp_fe;
        int          exp_err, cyc;
        exp_err = 0;
        exp_fe  = '0;
        for (int v = 0; v < 16; v++) begin
            gen_vec(m0, v, ea, eb, ec);
            g = {1'b0, ea} + {1'b0, eb} + {32'b0, ec};
            if (g[5]) begin
                if (exp_err == 0) exp_fe = {ea, eb, ec};
                exp_err++;
            end
        end
        fault = 1'b1;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        cyc = 1;
        while (done0 !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done0 !== 1'b1 || pass0 !== 1'b0) begin
            errors++;
            $display("FAIL stuck_pass: got done=%b pass=%b expected 1 0", done0, pass0);
        end
        checks++;
        if (err0 !== 16'(exp_err) || exp_err == 0) begin
            errors++;
            $display("FAIL stuck_err_count: got %0d expected %0d (nonzero)", err0, exp_err);
        end
        checks++;
        if (fe0 !== exp_fe) begin
            errors++;
            $display("FAIL stuck_first_err: got %h expected %h", fe0, exp_fe);
        end
        checks++;
        if (vec0 !== 16'd16) begin
            errors++;
            $display("FAIL stuck_vec_count: got %0d expected 16", vec0);
        end
        @(negedge clk);
    endtask

    task automatic test_latency();
        int cyc;
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        cyc = 1;
        while (done3 !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== 41) begin
            errors++;
            $display("FAIL lat3_done_cycle: got %0d expected 41", cyc);
        end
        checks++;
        if ({pass3, err3, vec3} !== {1'b1, 16'd0, 16'd8}) begin
            errors++;
            $display("FAIL lat3_result: got pass=%b err=%0d vec=%0d expected 1 0 8", pass3, err3, vec3);
        end
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        cyc = 1;
        while (done2 !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== 33) begin
            errors++;
            $display("FAIL lat2_done_cycle: got %0d expected 33", cyc);
        end
        checks++;
        if (pass2 !== 1'b0 || err2 == 16'd0) begin
            errors++;
            $display("FAIL lat2_mismatch: got pass=%b err=%0d expected 0 and nonzero", pass2, err2);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic [31:0] ea, eb;
        logic [32:0] g;
        logic        ec, saw_done;
        int          exp_err;
        exp_err = 0;
        for (int v = 0; v < 4; v++) begin
            gen_vec(m0, v, ea, eb, ec);
            g = {1'b0, ea} + {1'b0, eb} + {32'b0, ec};
            if (g[5]) exp_err++;
        end
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        repeat (9) @(negedge clk);
        abort0 = 1'b1;
        @(negedge clk) abort0 = 1'b0;
        checks++;
        if ({busy0, done0} !== 2'b00) begin
            errors++;
            $display("FAIL abort_busy: got busy=%b done=%b expected 0 0", busy0, done0);
        end
        checks++;
        if (vec0 !== 16'd4 || err0 !== 16'(exp_err)) begin
            errors++;
            $display("FAIL abort_counters: got vec=%0d err=%0d expected 4 %0d", vec0, err0, exp_err);
        end
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            saw_done = saw_done | done0;
        end
        checks++;
        if (saw_done !== 1'b0 || vec0 !== 16'd4) begin
            errors++;
            $display("FAIL abort_no_done: got done_seen=%b vec=%0d expected 0 4", saw_done, vec0);
        end
        start0 = 1'b1;
        abort0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        abort0 = 1'b0;
        checks++;
        if (busy0 !== 1'b0 || vec0 !== 16'd4) begin
            errors++;
            $display("FAIL abort_beats_start: got busy=%b vec=%0d expected 0 4", busy0, vec0);
        end
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        checks++;
        if ({busy0, vec0, err0, fe0} !== {1'b1, 16'd0, 16'd0, 65'd0}) begin
            errors++;
            $display("FAIL restart_clear: got busy=%b vec=%0d err=%0d fe=%h expected 1 0 0 0", busy0, vec0, err0, fe0);
        end
        abort0 = 1'b1;
        @(negedge clk) abort0 = 1'b0;
        fault = 1'b0;
    endtask

    task automatic test_rst_midrun();
        logic [31:0] ea, eb;
        logic        ec;
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        @(negedge clk);
        checks++;
        if (busy3 !== 1'b1 || {a3, b3} === 64'd0) begin
            errors++;
            $display("FAIL rst_pre_wait: got busy=%b a=%h b=%h expected busy and loaded operands", busy3, a3, b3);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a3, b3, cin3, busy3, done3, pass3} !== 68'd0) begin
            errors++;
            $display("FAIL rst_async_outputs: got %h/%h/%b busy=%b done=%b pass=%b expected all 0", a3, b3, cin3, busy3, done3, pass3);
        end
        checks++;
        if ({err3, vec3, fe3, err0, vec0} !== 129'd0) begin
            errors++;
            $display("FAIL rst_async_counters: got %h/%h/%h/%h/%h expected 0", err3, vec3, fe3, err0, vec0);
        end
        @(negedge clk) rst = 1'b0;
        m0 = SEED;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            gen_vec(m0, v, ea, eb, ec);
            checks++;
            if ({a0, b0, cin0} !== {ea, eb, ec}) begin
                errors++;
                $display("FAIL reseed_vec%0d: got %h/%h/%b expected %h/%h/%b", v, a0, b0, cin0, ea, eb, ec);
            end
            @(negedge clk);
        end
        abort0 = 1'b1;
        @(negedge clk) abort0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stuck_bit();
        test_latency();
        test_abort();
        test_rst_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
